// File: rtl/dmem_bank.sv
// Byte/half/word data memory with a one-outstanding request/response port; loads answer RD_LAT cycles after acceptance, stores/errors after 1.
// No response backpressure; req_ready drops only while a multi-cycle load is in flight. `DMEM_MISALIGN_TRAP_EN enables the misaligned-access trap.
module dmem_bank #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_sign,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_lat_cnt, w_lat_cnt_nxt;
    logic [31:0] r_hold, w_hold_nxt;
    logic [31:0] r_mem [DEPTH];

    logic        w_acc, w_size_ok, w_misalign, w_err, w_wr;
    logic [3:0]  w_be;
    logic [31:0] w_wdat_rep, w_word, w_ld;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_vld_nxt, w_err_nxt;
    logic [31:0] w_rdata_nxt;

    assign req_ready = (r_state == S_IDLE);
    assign w_acc     = req_valid & req_ready;
    assign w_size_ok = (req_size == 3'b001) | (req_size == 3'b010) | (req_size == 3'b100);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = (req_size[1] & req_addr[0]) | (req_size[2] & (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_err = ~w_size_ok | w_misalign;
    assign w_wr  = w_acc & req_we & ~w_err;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        w_be       = 4'b1111;
        w_wdat_rep = req_wdata;
        if (req_size[0]) begin
            w_be       = 4'b0001 << req_addr[1:0];
            w_wdat_rep = {4{req_wdata[7:0]}};
        end else if (req_size[1]) begin
            w_be       = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wdat_rep = {2{req_wdata[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[req_addr[ADDR_W-1:2]][8*b +: 8] <= w_wdat_rep[8*b +: 8];
            end
        end
    end

    assign w_word = r_mem[req_addr[ADDR_W-1:2]];
    assign w_byte = 8'(w_word >> {req_addr[1:0], 3'b000});
    assign w_half = 16'(w_word >> {req_addr[1], 4'b0000});

    always_comb begin
        w_ld = w_word;
        if (req_size[0]) begin
            w_ld = {{24{req_sign & w_byte[7]}}, w_byte};
        end else if (req_size[1]) begin
            w_ld = {{16{req_sign & w_half[15]}}, w_half};
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_hold_nxt    = r_hold;
        w_vld_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (req_we | w_err) begin
                        w_vld_nxt = 1'b1;
                        w_err_nxt = w_err;
                    end else if (RD_LAT == 1) begin
                        w_vld_nxt   = 1'b1;
                        w_rdata_nxt = w_ld;
                    end else begin
                        w_state_nxt   = S_WAIT;
                        w_lat_cnt_nxt = 3'(RD_LAT - 1);
                        w_hold_nxt    = w_ld;
                    end
                end
            end
            S_WAIT: begin
                w_lat_cnt_nxt = r_lat_cnt - 3'd1;
                // Leaving one edge early lets the response cycle run in IDLE and accept.
                if (r_lat_cnt == 3'd1) begin
                    w_state_nxt = S_IDLE;
                    w_vld_nxt   = 1'b1;
                    w_rdata_nxt = r_hold;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 3'd0;
            r_hold    <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_hold    <= w_hold_nxt;
            rsp_valid <= w_vld_nxt;
            rsp_rdata <= w_rdata_nxt;
            rsp_err   <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_dmem_bank.sv
// Four instances (RD_LAT 1..4) exercised one at a time against a behavioural memory model.
module tb_dmem_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [11:0] req_addr = 12'h0;
    logic [31:0] req_wdata = 32'h0;
    int          sel = 0;

    logic        w_ready [4];
    logic        w_vld [4];
    logic        w_err [4];
    logic [31:0] w_rdata [4];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            dmem_bank #(.ADDR_W(12), .RD_LAT(g + 1)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .req_valid (req_valid && (sel == g)),
                .req_ready (w_ready[g]),
                .req_we    (req_we),
                .req_sign  (req_sign),
                .req_size  (req_size),
                .req_addr  (req_addr),
                .req_wdata (req_wdata),
                .rsp_valid (w_vld[g]),
                .rsp_rdata (w_rdata[g]),
                .rsp_err   (w_err[g])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Behavioural model: per-instance word memory plus the single expected response.
    logic [31:0] mm [4][1024];
    int          ecnt = 0;
    int          exp_due = -1;
    int          busy_till = -1;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;

    task automatic m_accept(input int e);
        int          idx, lane, hl;
        logic [31:0] w, v;
        bit          err;
        idx  = int'(req_addr) / 4;
        lane = int'(req_addr) % 4;
        hl   = (int'(req_addr) / 2) % 2;
        err  = !((req_size == 3'd1) || (req_size == 3'd2) || (req_size == 3'd4));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (req_size == 3'd2 && (int'(req_addr) % 2) != 0) err = 1;
        if (req_size == 3'd4 && (int'(req_addr) % 4) != 0) err = 1;
`endif
        w = mm[sel][idx];
        v = 32'h0;
        if (err || req_we) begin
            if (!err) begin
                if (req_size == 3'd1)
                    mm[sel][idx] = (w & ~(32'hFF << (8 * lane))) | ({24'h0, req_wdata[7:0]} << (8 * lane));
                else if (req_size == 3'd2)
                    mm[sel][idx] = (w & ~(32'hFFFF << (16 * hl))) | ({16'h0, req_wdata[15:0]} << (16 * hl));
                else
                    mm[sel][idx] = req_wdata;
            end
            exp_due = e + 1;
        end else begin
            if (req_size == 3'd1) begin
                v = (w >> (8 * lane)) & 32'hFF;
                if (req_sign && v[7]) v = v | 32'hFFFFFF00;
            end else if (req_size == 3'd2) begin
                v = (w >> (16 * hl)) & 32'hFFFF;
                if (req_sign && v[15]) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            exp_due   = e + sel + 1;
            busy_till = e + sel;
        end
        exp_rdata = v;
        exp_err   = err;
    endtask

    always @(posedge clk) begin
        ecnt++;
        if (!rst_n) begin
            exp_due   = -1;
            busy_till = -1;
        end else if (req_valid && ecnt > busy_till) begin
            m_accept(ecnt);
        end
    end

    always @(negedge clk) begin : cmp
        int c;
        bit ev;
        c  = ecnt + 1;
        ev = (exp_due == c);
        chk("req_ready", 32'(w_ready[sel]), 32'(c > busy_till));
        chk("rsp_valid", 32'(w_vld[sel]), 32'(ev));
        chk("rsp_rdata", w_rdata[sel], ev ? exp_rdata : 32'h0);
        chk("rsp_err", 32'(w_err[sel]), ev ? 32'(exp_err) : 32'h0);
    end

    task automatic do_req(input bit we, input bit sg, input logic [2:0] sz, input logic [11:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int busy);
        bit rdy;
        int n;
        rd = 32'h0; er = 1'b0; lat = 0; busy = 0;
        @(negedge clk);
        #1;
        req_we = we; req_sign = sg; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        forever begin
            rdy = w_ready[sel];
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 10) break;
            #1;
        end
        #1 req_valid = 1'b0;
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance within 10 cycles");
            return;
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (w_vld[sel]) begin
                rd = w_rdata[sel]; er = w_err[sel]; lat = i;
                return;
            end
            if (!w_ready[sel]) busy++;
        end
        checks++; errors++;
        $display("FAIL rsp_timeout: got no rsp_valid expected one within 12 cycles");
    endtask

    task automatic acc(input bit we, input bit sg, input logic [2:0] sz, input logic [11:0] a,
                       input logic [31:0] wd, input string nm, input logic [31:0] xr,
                       input logic xe, input int xl);
        logic [31:0] rd;
        logic        er;
        int          lat, busy;
        do_req(we, sg, sz, a, wd, rd, er, lat, busy);
        chk({nm, "_rdata"}, rd, xr);
        chk({nm, "_err"}, 32'(er), 32'(xe));
        chk({nm, "_lat"}, lat, xl);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        int          lat, busy, vc;
        logic [2:0]  sz;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_ready", 32'(w_ready[i]), 32'h1);
            chk("rst_valid", 32'(w_vld[i]), 32'h0);
            chk("rst_rdata", w_rdata[i], 32'h0);
        end

        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            #1 sel = s;
            for (int w = 16; w < 32; w++) do_req(1'b1, 1'b0, 3'b100, 12'(w * 4), $urandom, rd, er, lat, busy);

            acc(1'b1, 1'b0, 3'b100, 12'h010, 32'h11223344, "st_word", 32'h0, 1'b0, 1);
            acc(1'b1, 1'b0, 3'b001, 12'h012, 32'h000000A5, "st_byte", 32'h0, 1'b0, 1);
            acc(1'b0, 1'b0, 3'b100, 12'h010, 32'h0, "ld_word", 32'h11A53344, 1'b0, s + 1);
            acc(1'b0, 1'b1, 3'b001, 12'h012, 32'h0, "ld_byte_s", 32'hFFFFFFA5, 1'b0, s + 1);
            acc(1'b0, 1'b0, 3'b001, 12'h012, 32'h0, "ld_byte_u", 32'h000000A5, 1'b0, s + 1);
            acc(1'b1, 1'b0, 3'b010, 12'h016, 32'h00008001, "st_half", 32'h0, 1'b0, 1);
            do_req(1'b0, 1'b1, 3'b010, 12'h016, 32'h0, rd, er, lat, busy);
            chk("ld_half_rdata", rd, 32'hFFFF8001);
            chk("ld_half_lat", lat, s + 1);
            chk("ld_half_busy", busy, s);
`ifdef DMEM_MISALIGN_TRAP_EN
            acc(1'b0, 1'b0, 3'b100, 12'h013, 32'h0, "ld_misalign", 32'h0, 1'b1, 1);
            acc(1'b1, 1'b0, 3'b100, 12'h011, 32'h99999999, "st_misalign", 32'h0, 1'b1, 1);
`else
            acc(1'b0, 1'b0, 3'b100, 12'h013, 32'h0, "ld_misalign", 32'h11A53344, 1'b0, s + 1);
`endif
            acc(1'b1, 1'b0, 3'b011, 12'h010, 32'hDEADBEEF, "st_badsize", 32'h0, 1'b1, 1);
            acc(1'b0, 1'b0, 3'b000, 12'h010, 32'h0, "ld_nosize", 32'h0, 1'b1, 1);
            acc(1'b0, 1'b0, 3'b100, 12'h010, 32'h0, "ld_unchanged", 32'h11A53344, 1'b0, s + 1);

            for (int n = 0; n < 150; n++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: sz = 3'b001;
                    3, 4, 5: sz = 3'b010;
                    6, 7, 8: sz = 3'b100;
                    default: sz = 3'($urandom_range(0, 7));
                endcase
                do_req(1'($urandom), 1'($urandom), sz, 12'($urandom_range(64, 127)), $urandom, rd, er, lat, busy);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end

        // Store presented in the response cycle of an RD_LAT=2 load.
        @(negedge clk);
        #1 sel = 1;
        @(negedge clk);
        #1;
        req_we = 1'b0; req_sign = 1'b0; req_size = 3'b100; req_addr = 12'h010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_busy_ready", 32'(w_ready[1]), 32'h0);
        @(negedge clk);
        chk("b2b_ld_valid", 32'(w_vld[1]), 32'h1);
        chk("b2b_ld_rdata", w_rdata[1], 32'h11A53344);
        chk("b2b_rsp_ready", 32'(w_ready[1]), 32'h1);
        #1;
        req_we = 1'b1; req_addr = 12'h020; req_wdata = 32'h55AA55AA; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_st_valid", 32'(w_vld[1]), 32'h1);
        chk("b2b_st_rdata", w_rdata[1], 32'h0);
        acc(1'b0, 1'b0, 3'b100, 12'h020, 32'h0, "b2b_readback", 32'h55AA55AA, 1'b0, 2);

        // Reset during the wait of an RD_LAT=4 load.
        @(negedge clk);
        #1 sel = 3;
        @(negedge clk);
        #1;
        req_we = 1'b0; req_size = 3'b100; req_addr = 12'h010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        vc = 0;
        repeat (8) begin
            @(negedge clk);
            if (w_vld[3]) vc++;
        end
        chk("rstwait_no_rsp", vc, 0);
        chk("rstwait_ready", 32'(w_ready[3]), 32'h1);
        acc(1'b0, 1'b0, 3'b100, 12'h010, 32'h0, "rstwait_mem_kept", 32'h11A53344, 1'b0, 4);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
